// File: rtl/multi_pulse_gen_if.sv
// Button/mode/pulse/level bundle for multi_pulse_gen.
// The master drives buttons and modes; the slave (the pulse generator) drives pulses and levels.
interface multi_pulse_gen_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]   button_i;
    logic [2*N_CH-1:0] mode_i;
    logic [N_CH-1:0]   pulse_o;
    logic [N_CH-1:0]   level_o;

    modport master (
        output button_i,
        output mode_i,
        input  pulse_o,
        input  level_o
    );

    modport slave (
        input  button_i,
        input  mode_i,
        output pulse_o,
        output level_o
    );
endinterface

// File: rtl/multi_pulse_gen.sv
// N-channel synchronise / debounce / edge-qualify / stretch pulse generator.
// Optional auto-repeat while a rising-mode button is held: define MULTI_PULSE_AUTOREPEAT_EN.
module multi_pulse_gen #(
    parameter int N_CH          = 4,
    parameter int DEB_CYCLES    = 16,
    parameter int PULSE_LEN     = 1,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    multi_pulse_gen_if.slave   bus
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } state_e;

    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    logic [N_CH-1:0] pulse_vec;
    logic [N_CH-1:0] level_vec;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.button_i;
            sync2_q <= sync1_q;
        end
    end

    assign bus.pulse_o = pulse_vec;
    assign bus.level_o = level_vec;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic          s;
        logic [1:0]    mode;
        logic          last_sample;
        logic          rise_evt;
        logic          fall_evt;
        logic          repeat_evt;
        logic          qual_evt;
        state_e        state_q;
        logic [DW-1:0] deb_cnt_q;
        logic          level_q;
        logic [PW-1:0] pulse_cnt_q;
        logic [PW-1:0] pulse_cnt_d;
        logic          pulse_q;

        assign s    = sync2_q[c];
        assign mode = bus.mode_i[2*c +: 2];

        // deb_cnt_q holds how many differing samples were already seen, so the
        // current one is the DEB_CYCLES-th when the count reaches DEB_CYCLES-1.
        assign last_sample = (deb_cnt_q == DW'(DEB_CYCLES - 1));
        assign rise_evt    =  s && last_sample && (state_q == IDLE_LO || state_q == WAIT_HI);
        assign fall_evt    = !s && last_sample && (state_q == IDLE_HI || state_q == WAIT_LO);

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state_q   <= IDLE_LO;
                deb_cnt_q <= '0;
                level_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE_LO: begin
                        if (rise_evt) begin
                            state_q <= IDLE_HI;
                            level_q <= 1'b1;
                        end else if (s) begin
                            state_q   <= WAIT_HI;
                            deb_cnt_q <= DW'(1);
                        end
                    end
                    WAIT_HI: begin
                        if (!s) begin
                            state_q   <= IDLE_LO;
                            deb_cnt_q <= '0;
                        end else if (rise_evt) begin
                            state_q   <= IDLE_HI;
                            level_q   <= 1'b1;
                            deb_cnt_q <= '0;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end
                    IDLE_HI: begin
                        if (fall_evt) begin
                            state_q <= IDLE_LO;
                            level_q <= 1'b0;
                        end else if (!s) begin
                            state_q   <= WAIT_LO;
                            deb_cnt_q <= DW'(1);
                        end
                    end
                    WAIT_LO: begin
                        if (s) begin
                            state_q   <= IDLE_HI;
                            deb_cnt_q <= '0;
                        end else if (fall_evt) begin
                            state_q   <= IDLE_LO;
                            level_q   <= 1'b0;
                            deb_cnt_q <= '0;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE_LO;
                        deb_cnt_q <= '0;
                    end
                endcase
            end
        end

        assign qual_evt = (rise_evt && mode[0]) || (fall_evt && mode[1]) || repeat_evt;

        // A reload while still counting extends the pulse without a low gap.
        always_comb begin
            pulse_cnt_d = pulse_cnt_q;
            if (qual_evt) begin
                pulse_cnt_d = PW'(PULSE_LEN);
            end else if (pulse_cnt_q != '0) begin
                pulse_cnt_d = pulse_cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                pulse_cnt_q <= '0;
                pulse_q     <= 1'b0;
            end else begin
                pulse_cnt_q <= pulse_cnt_d;
                pulse_q     <= (pulse_cnt_d != '0);
            end
        end

`ifdef MULTI_PULSE_AUTOREPEAT_EN
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW      = $clog2(RPT_MAX + 1);

        logic          rpt_active_q;
        logic [RW-1:0] rpt_cnt_q;

        assign repeat_evt = rpt_active_q && mode[0] && (rpt_cnt_q == RW'(1));

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                rpt_active_q <= 1'b0;
                rpt_cnt_q    <= '0;
            end else if (fall_evt || !mode[0]) begin
                rpt_active_q <= 1'b0;
                rpt_cnt_q    <= '0;
            end else if (rise_evt) begin
                rpt_active_q <= 1'b1;
                rpt_cnt_q    <= RW'(REPEAT_DELAY);
            end else if (rpt_active_q) begin
                if (rpt_cnt_q == RW'(1)) begin
                    rpt_cnt_q <= RW'(REPEAT_PERIOD);
                end else begin
                    rpt_cnt_q <= rpt_cnt_q - 1'b1;
                end
            end
        end
`else
        assign repeat_evt = 1'b0;
`endif

        assign pulse_vec[c] = pulse_q;
        assign level_vec[c] = level_q;
    end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Scoreboard bench for multi_pulse_gen: two instances (DEB 4/PULSE 3 and DEB 1/PULSE 8)
// driven in parallel and checked every cycle against a sample-history reference model.
module tb_multi_pulse_gen;

    localparam int REP_DELAY  = 20;
    localparam int REP_PERIOD = 10;
`ifdef MULTI_PULSE_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk;
    logic rstN;

    multi_pulse_gen_if #(.N_CH(2)) busA ();
    multi_pulse_gen_if #(.N_CH(2)) busB ();

    multi_pulse_gen #(
        .N_CH(2), .DEB_CYCLES(4), .PULSE_LEN(3),
        .REPEAT_DELAY(REP_DELAY), .REPEAT_PERIOD(REP_PERIOD)
    ) dutA (
        .clk_i   (clk),
        .rst_n_i (rstN),
        .bus     (busA)
    );

    multi_pulse_gen #(
        .N_CH(2), .DEB_CYCLES(1), .PULSE_LEN(8),
        .REPEAT_DELAY(REP_DELAY), .REPEAT_PERIOD(REP_PERIOD)
    ) dutB (
        .clk_i   (clk),
        .rst_n_i (rstN),
        .bus     (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int numChecks = 0;
    int numFails  = 0;

    logic [7:0] expQ[$];

    logic [1:0] curBtn;
    logic [3:0] curMode;
    logic       curRstn;

    int         debOf[2] = '{4, 1};
    int         lenOf[2] = '{3, 8};
    logic [15:0] hist[2][2];
    int         histN[2][2];
    logic       p1[2][2];
    logic       p2[2][2];
    logic       lvl[2][2];
    int         pulseEnd[2][2];
    logic       repOn[2][2];
    int         repNext[2][2];
    int         mcyc = 0;

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                hist[i][c]     = '0;
                histN[i][c]    = 0;
                p1[i][c]       = 1'b0;
                p2[i][c]       = 1'b0;
                lvl[i][c]      = 1'b0;
                pulseEnd[i][c] = 0;
                repOn[i][c]    = 1'b0;
                repNext[i][c]  = 0;
            end
        end
    endtask

    // A level change is accepted once the last DEB samples reaching the debouncer all
    // disagree with the current level; a qualified event holds the pulse for PULSE_LEN edges.
    task automatic modelStep(input logic [1:0] b, input logic [3:0] m, output logic [7:0] e);
        logic [15:0] mask;
        logic acc, rise, fall, rep, qual, modeRise, modeFall;
        e = '0;
        mcyc++;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                modeRise = m[2*c];
                modeFall = m[2*c+1];
                hist[i][c] = {hist[i][c][14:0], p2[i][c]};
                if (histN[i][c] < 16) histN[i][c]++;
                mask = 16'((32'd1 << debOf[i]) - 32'd1);
                acc  = (histN[i][c] >= debOf[i]) &&
                       ((hist[i][c] & mask) == (lvl[i][c] ? 16'h0000 : mask));
                rise = acc && !lvl[i][c];
                fall = acc &&  lvl[i][c];
                if (acc) lvl[i][c] = !lvl[i][c];
                rep = 1'b0;
                if (REP_EN) begin
                    rep = repOn[i][c] && modeRise && (mcyc == repNext[i][c]);
                    if (rep) repNext[i][c] += REP_PERIOD;
                    if (fall || !modeRise) begin
                        repOn[i][c] = 1'b0;
                    end else if (rise) begin
                        repOn[i][c]   = 1'b1;
                        repNext[i][c] = mcyc + REP_DELAY;
                    end
                end
                qual = (rise && modeRise) || (fall && modeFall) || rep;
                if (qual) pulseEnd[i][c] = mcyc + lenOf[i];
                e[i*4 + c]     = (mcyc < pulseEnd[i][c]);
                e[i*4 + 2 + c] = lvl[i][c];
                p2[i][c] = p1[i][c];
                p1[i][c] = b[c];
            end
        end
    endtask

    task automatic applyStimulus(input logic [1:0] b, input logic [3:0] m, input logic rn);
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (curRstn) modelStep(curBtn, curMode, e);
        else         e = '0;
        busA.button_i = b;
        busB.button_i = b;
        busA.mode_i   = m;
        busB.mode_i   = m;
        rstN          = rn;
        if (!rn) begin
            modelReset();
            e = '0;
        end
        expQ.push_back(e);
        curBtn  = b;
        curMode = m;
        curRstn = rn;
    endtask

    task automatic holdFor(input logic [1:0] b, input logic [3:0] m, input int n);
        for (int k = 0; k < n; k++) applyStimulus(b, m, 1'b1);
    endtask

    task automatic resetFor(input logic [1:0] b, input int n);
        for (int k = 0; k < n; k++) applyStimulus(b, curMode, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] got, input logic [1:0] want);
        numChecks++;
        if (got !== want) begin
            numFails++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
        end
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pulseA", busA.pulse_o, e[1:0]);
                checkOutput("levelA", busA.level_o, e[3:2]);
                checkOutput("pulseB", busB.pulse_o, e[5:4]);
                checkOutput("levelB", busB.level_o, e[7:6]);
            end
        end
    end

    initial begin : stimulus
        logic [1:0] nb;
        logic [3:0] nm;
        modelReset();
        rstN          = 1'b0;
        curRstn       = 1'b0;
        curBtn        = 2'b11;
        curMode       = 4'b0000;
        busA.button_i = 2'b11;
        busB.button_i = 2'b11;
        busA.mode_i   = 4'b0000;
        busB.mode_i   = 4'b0000;

        $display("[TB] reset with buttons held high, then release low");
        resetFor(2'b11, 4);
        holdFor(2'b00, 4'b0000, 6);

        $display("[TB] channel 0 rising edge");
        holdFor(2'b00, 4'b0001, 3);
        holdFor(2'b01, 4'b0001, 14);
        holdFor(2'b00, 4'b0001, 12);

        $display("[TB] bounce rejection then settled press");
        holdFor(2'b01, 4'b0001, 3);
        holdFor(2'b00, 4'b0001, 10);
        holdFor(2'b01, 4'b0001, 2);
        holdFor(2'b00, 4'b0001, 1);
        holdFor(2'b01, 4'b0001, 12);
        holdFor(2'b00, 4'b0001, 12);

        $display("[TB] mixed modes, simultaneous toggles");
        holdFor(2'b11, 4'b1110, 20);
        holdFor(2'b00, 4'b1110, 15);

        $display("[TB] retrigger extension then reset mid-pulse");
        holdFor(2'b00, 4'b1111, 3);
        holdFor(2'b01, 4'b1111, 4);
        holdFor(2'b00, 4'b1111, 6);
        resetFor(2'b00, 2);
        holdFor(2'b00, 4'b1111, 4);

        $display("[TB] long hold for auto-repeat");
        holdFor(2'b01, 4'b0101, 70);
        holdFor(2'b00, 4'b0101, 20);

        $display("[TB] randomized phase");
        nm = 4'b0101;
        for (int it = 0; it < 45; it++) begin
            if (it % 15 == 14) begin
                resetFor(2'($urandom_range(0, 3)), 2);
            end
            nb = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) nm = 4'($urandom);
            holdFor(nb, nm, $urandom_range(1, 12));
        end
        holdFor(2'b00, nm, 12);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/multi_pulse_gen.md
Name: multi_pulse_gen

Overview:
Parametrised successor to the single-button pulse FSM. Takes N_CH raw asynchronous button inputs. Each channel is synchronised, debounced, edge-qualified per a runtime mode, and produces a stretched, retriggerable output pulse. Sits between the board push-buttons and user logic or LEDs in the top level.

Parameters:
N_CH, 4, number of independent channels (>=1)
DEB_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (>=1)
PULSE_LEN, 1, output pulse width in clk cycles (>=1)
REPEAT_DELAY, 1000, cycles from rising-pulse start to first auto-repeat pulse (used only with optional feature, >=PULSE_LEN)
REPEAT_PERIOD, 250, cycles between auto-repeat pulse starts (used only with optional feature, >PULSE_LEN)

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  reset, asynchronous, active-low
button_i  input  N_CH  raw button levels, asynchronous to clk_i
mode_i  input  2*N_CH  per-channel edge mode, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both
pulse_o  output  N_CH  registered output pulses
level_o  output  N_CH  registered debounced level per channel

Behaviour:
- One clock (clk_i); reset asynchronous, active-low (rst_n_i). Channels fully independent; no shared state.
- Reset: pulse_o=0, level_o=0, all counters 0, sync flops 0, every channel FSM in IDLE_LO. Assertion mid-operation aborts debounce and pulses at once (pulse_o drops asynchronously).
- Synchroniser: 2 flops per channel; s = second flop output.
- Per-channel FSM states:
  - IDLE_LO: s==0 stays; s==1 -> WAIT_HI, cnt=1.
  - WAIT_HI: s==0 -> IDLE_LO, cnt=0; s==1 and cnt==DEB_CYCLES -> IDLE_HI, level_o<=1, rising event; else cnt++.
  - IDLE_HI and WAIT_LO mirror these with falling event.
- DEB_CYCLES=1: transition on the first cycle s differs from level_o.
- Latency: if edge k is the first to sample the new value and the input then stays stable, level_o and pulse_o update after edge k+1+DEB_CYCLES.
- Bounce: any return of s to the stable level before acceptance restarts debounce. No event, level_o unchanged.
- Event qualification uses mode_i in the same cycle the level is accepted. Mode 00 produces no pulse, but level_o still tracks.
- Pulse stretcher: per-channel counter loaded with PULSE_LEN on a qualified event. pulse_o = (counter != 0), registered. The counter decrements each cycle.
- Retrigger: a qualified event while the counter is nonzero reloads it to PULSE_LEN. The pulse is extended, never split, with no low cycle.
- A mode change during an active pulse does not truncate it.
- A button held high through reset release is seen as a rising change and debounced normally.
- Counter widths: $clog2(DEB_CYCLES+1) and $clog2(PULSE_LEN+1); no wrap occurs in legal operation.

Optional Feature:
Macro MULTI_PULSE_AUTOREPEAT_EN.
- Defined:
  - While level_o[c]==1 and mode bit 2c is set, a repeat counter starts at the rising event.
  - After REPEAT_DELAY cycles a qualified event is generated; further events follow every REPEAT_PERIOD cycles.
  - Each event loads the stretcher like a normal event.
  - The counter clears when level falls, when mode bit 2c clears, or on reset.
- Not defined: no repeat logic is synthesised, and REPEAT_* parameters are ignored.

Test Plan:
1. Bench uses N_CH=2, DEB_CYCLES=4, PULSE_LEN=3. Hold rst_n_i=0 with button_i=2'b11 -> pulse_o=0, level_o=0. Release with button_i=0 -> outputs stay 0.
2. mode_i=4'b0001; button_i[0] 0->1 first sampled at edge 10 -> level_o[0]=1 and pulse_o[0]=1 after edge 15. pulse_o[0] is high for exactly 3 cycles, then 0. Channel 1 stays 0.
3. button_i[0] high for 3 cycles then low (bounce) -> no pulse, level_o[0]=0. Next apply 2 high / 1 low / 5 high -> a single pulse, 5 edges after the final rise is sampled.
4. mode_i=4'b1110: ch1 both edges, ch0 falling. Toggle both buttons simultaneously (rise, then fall 20 cycles later) -> ch1 pulses on both edges; ch0 pulses on the fall only. Timing identical across channels.
5. Instance with PULSE_LEN=8, DEB_CYCLES=1, mode 11: rise, then fall 4 cycles after level accepted -> pulse_o stays high continuously, 4+8=12 cycles total. Then assert rst_n_i mid-pulse -> pulse_o=0 immediately.
6. With MULTI_PULSE_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10: hold the button 60 cycles after acceptance -> pulses start at t=0, 20, 30, 40, 50 relative to the first. Release -> no further pulses. Without the macro -> single pulse only.
